// File: rtl/mmio_key_art_responder_pkg.sv
// Shared constants for the MMIO key/ART responder: register offsets, status bit
// positions, interrupt codes and the interrupt FSM state encoding.
package mmio_key_art_responder_pkg;

  localparam logic [63:0] KEY_DATA_OFS = 64'd0;
  localparam logic [63:0] KEY_STAT_OFS = 64'd8;

  localparam int STAT_KEY_NONEMPTY = 0;
  localparam int STAT_TX_FULL      = 1;
  localparam int STAT_KEY_OVF      = 2;
  localparam int STAT_TX_OVF       = 3;
  localparam int STAT_COUNT_LSB    = 8;

  localparam logic [3:0] IRQ_NONE = 4'd0;
  localparam logic [3:0] IRQ_KEY  = 4'd1;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

  // Status word layout: count in [15:8], flags in [3:0], everything else zero.
  function automatic logic [63:0] status_word(input logic [7:0] key_count,
                                              input logic tx_ovf,
                                              input logic key_ovf,
                                              input logic tx_full,
                                              input logic key_nonempty);
    return {48'b0, key_count, 4'b0, tx_ovf, key_ovf, tx_full, key_nonempty};
  endfunction

endpackage

// File: rtl/mmio_key_art_responder_sync_fifo.sv
// Single-clock FIFO with combinational head output. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_key_art_responder.sv
// MMIO responder: key receive FIFO read by the CPU, TX FIFO written by the CPU
// and drained by a UART. Define MMIO_KEY_IRQ_EN to build the key interrupt FSM.
`ifndef Key_base
`define Key_base 64'h0000_0000_1000_0000
`endif
`ifndef Art_base
`define Art_base 64'h0000_0000_1000_0100
`endif

module mmio_key_art_responder
  import mmio_key_art_responder_pkg::*;
#(
  parameter logic [63:0] KEY_BASE   = `Key_base,
  parameter logic [63:0] ART_BASE   = `Art_base,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [63:0] bus_write_data,
  output logic [63:0] bus_read_data,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_ack,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          key_rd, stat_rd, tx_wr;
  logic          key_pop, tx_pop;
  logic          key_full, key_empty, tx_full, tx_empty;
  logic [7:0]    key_head;
  logic [CW-1:0] key_count, tx_count;
  logic          key_drop, tx_drop;
  logic          key_ovf, tx_ovf;

  assign key_rd  = bus_read_enable && (bus_address == KEY_BASE + KEY_DATA_OFS);
  assign stat_rd = bus_read_enable && (bus_address == KEY_BASE + KEY_STAT_OFS);
  assign tx_wr   = bus_write_enable && (bus_address == ART_BASE);
  assign key_pop = key_rd && !key_empty;
  assign tx_pop  = tx_ready && !tx_empty;

  // A byte is lost only when the FIFO is full and nothing leaves that cycle.
  assign key_drop = key_valid && key_full && !key_pop;
  assign tx_drop  = tx_wr && tx_full && !tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_key_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (key_valid),
    .push_data (key_data),
    .pop       (key_pop),
    .pop_data  (key_head),
    .full      (key_full),
    .empty     (key_empty),
    .count     (key_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_wr),
    .push_data (bus_write_data[7:0]),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // UART side: valid/ready, byte moves on a cycle with tx_valid && tx_ready;
  // the head stays put until then.
  assign tx_valid = !tx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_read_data <= '0;
      key_ovf       <= 1'b0;
      tx_ovf        <= 1'b0;
    end else begin
      if (bus_read_enable) begin
        if (key_rd) begin
          bus_read_data <= key_empty ? 64'b0 : {55'b0, 1'b1, key_head};
        end else if (stat_rd) begin
          bus_read_data <= status_word(8'(key_count), tx_ovf, key_ovf,
                                       tx_full, !key_empty);
        end else begin
          bus_read_data <= '0;
        end
      end
      // A drop in the same cycle as a status read stays visible for the next one.
      key_ovf <= (key_ovf && !stat_rd) || key_drop;
      tx_ovf  <= (tx_ovf && !stat_rd) || tx_drop;
    end
  end

`ifdef MMIO_KEY_IRQ_EN
  irq_state_t irq_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_state        <= IRQ_IDLE;
      interrupt_vector <= IRQ_NONE;
    end else begin
      case (irq_state)
        IRQ_IDLE: begin
          if (!key_empty) begin
            irq_state        <= IRQ_REQ;
            interrupt_vector <= IRQ_KEY;
          end
        end
        IRQ_REQ: begin
          if (interrupt_ack) begin
            irq_state        <= IRQ_SERVICE;
            interrupt_vector <= IRQ_NONE;
          end
        end
        IRQ_SERVICE: begin
          if (key_rd) irq_state <= IRQ_IDLE;
        end
        default: begin
          irq_state        <= IRQ_IDLE;
          interrupt_vector <= IRQ_NONE;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, bus_write_data[63:8], tx_count};
`else
  assign interrupt_vector = IRQ_NONE;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus_write_data[63:8], tx_count, interrupt_ack};
`endif

endmodule

// File: tb/tb_mmio_key_art_responder.sv
// Self-checking bench for mmio_key_art_responder: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_mmio_key_art_responder;

  localparam logic [63:0] KEY_BASE = 64'h0000_0000_1000_0000;
  localparam logic [63:0] ART_BASE = 64'h0000_0000_1000_0100;
  localparam logic [63:0] STAT_ADDR = KEY_BASE + 64'd8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] bus_address;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [63:0] bus_write_data;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack;
  logic        key_valid;
  logic [7:0]  key_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0]  mk_q[$];
  logic [7:0]  mt_q[$];
  bit          m_kovf;
  bit          m_tovf;
  logic [63:0] m_rd;

  mmio_key_art_responder #(
    .KEY_BASE   (KEY_BASE),
    .ART_BASE   (ART_BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_write_data   (bus_write_data),
    .bus_read_data    (bus_read_data),
    .interrupt_vector (interrupt_vector),
    .interrupt_ack    (interrupt_ack),
    .key_valid        (key_valid),
    .key_data         (key_data),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_ready         (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reset            = 1'b0;
    bus_address      = 64'h0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    bus_write_data   = 64'h0;
    interrupt_ack    = 1'b0;
    key_valid        = 1'b0;
    key_data         = 8'h0;
    tx_ready         = 1'b0;
  endtask

  // Apply the register-level rules to the queues for the cycle just clocked.
  task automatic model_update();
    logic [63:0] stat;
    if (reset) begin
      mk_q.delete();
      mt_q.delete();
      m_kovf = 1'b0;
      m_tovf = 1'b0;
      m_rd   = 64'h0;
      return;
    end
    stat = 64'h0;
    stat[15:8] = 8'(mk_q.size());
    stat[3] = m_tovf;
    stat[2] = m_kovf;
    stat[1] = (mt_q.size() == DEPTH);
    stat[0] = (mk_q.size() != 0);
    if (bus_read_enable) begin
      if (bus_address == KEY_BASE) begin
        if (mk_q.size() != 0) m_rd = {55'b0, 1'b1, mk_q.pop_front()};
        else m_rd = 64'h0;
      end else if (bus_address == STAT_ADDR) begin
        m_rd = stat;
        m_kovf = 1'b0;
        m_tovf = 1'b0;
      end else begin
        m_rd = 64'h0;
      end
    end
    if (tx_ready && mt_q.size() != 0) void'(mt_q.pop_front());
    if (bus_write_enable && bus_address == ART_BASE) begin
      if (mt_q.size() < DEPTH) mt_q.push_back(bus_write_data[7:0]);
      else m_tovf = 1'b1;
    end
    if (key_valid) begin
      if (mk_q.size() < DEPTH) mk_q.push_back(key_data);
      else m_kovf = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_update();
    chk("rd_data", bus_read_data, m_rd);
    chk("tx_valid", {63'b0, tx_valid}, {63'b0, mt_q.size() != 0});
    if (mt_q.size() != 0) chk("tx_data", {56'b0, tx_data}, {56'b0, mt_q[0]});
`ifndef MMIO_KEY_IRQ_EN
    chk("irq_tied", {60'b0, interrupt_vector}, 64'h0);
`endif
  endtask

  task automatic read_at(input logic [63:0] addr);
    bus_read_enable = 1'b1;
    bus_address     = addr;
    cycle();
    bus_read_enable = 1'b0;
    bus_address     = 64'h0;
  endtask

  task automatic push_key(input logic [7:0] b);
    key_valid = 1'b1;
    key_data  = b;
    cycle();
    key_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("reset_rd", bus_read_data, 64'h0);
    chk("reset_txv", {63'b0, tx_valid}, 64'h0);
    chk("reset_irq", {60'b0, interrupt_vector}, 64'h0);

`ifdef MMIO_KEY_IRQ_EN
    push_key(8'h41);
    push_key(8'h42);
    chk("irq_raise", {60'b0, interrupt_vector}, 64'h1);
    interrupt_ack = 1'b1; cycle(); interrupt_ack = 1'b0;
    chk("irq_ack_drop", {60'b0, interrupt_vector}, 64'h0);
    read_at(KEY_BASE);
    chk("irq_rd1", bus_read_data, 64'h141);
    cycle();
    chk("irq_rereq", {60'b0, interrupt_vector}, 64'h1);
    interrupt_ack = 1'b1; cycle(); interrupt_ack = 1'b0;
    read_at(KEY_BASE);
    chk("irq_rd2", bus_read_data, 64'h142);
    cycle(); cycle();
    chk("irq_stays_low", {60'b0, interrupt_vector}, 64'h0);
    interrupt_ack = 1'b1; cycle(); interrupt_ack = 1'b0;
    chk("irq_ack_ignored", {60'b0, interrupt_vector}, 64'h0);
`else
    push_key(8'h5a);
    interrupt_ack = 1'b1; cycle(); interrupt_ack = 1'b0;
    cycle();
    chk("noirq_vec", {60'b0, interrupt_vector}, 64'h0);
    read_at(KEY_BASE);
    chk("noirq_data", bus_read_data, 64'h15a);
`endif

    // Overflow of the key FIFO, then sticky clear
    for (int i = 0; i <= DEPTH; i++) push_key(8'(8'h10 + i));
    read_at(STAT_ADDR);
    chk("ovf_count", {56'b0, bus_read_data[15:8]}, 64'd16);
    chk("ovf_flag", {63'b0, bus_read_data[2]}, 64'h1);
    read_at(STAT_ADDR);
    chk("ovf_cleared", {63'b0, bus_read_data[2]}, 64'h0);

    // Full FIFO, simultaneous push and pop
    key_valid = 1'b1; key_data = 8'hee;
    read_at(KEY_BASE);
    key_valid = 1'b0;
    chk("full_pop_head", bus_read_data, 64'h110);
    read_at(STAT_ADDR);
    chk("full_pp_status", bus_read_data, 64'h1001);

    for (int i = 0; i < DEPTH; i++) read_at(KEY_BASE);
    chk("drain_last", bus_read_data, 64'h1ee);

    // Unmapped and empty reads
    read_at(64'h0);
    chk("unmapped", bus_read_data, 64'h0);
    read_at(KEY_BASE);
    chk("empty_key", bus_read_data, 64'h0);
    read_at(STAT_ADDR);
    chk("empty_status", bus_read_data, 64'h0);

    // TX stall then handshake
    bus_write_enable = 1'b1; bus_address = ART_BASE; bus_write_data = 64'hffff_0055;
    cycle();
    bus_write_enable = 1'b0; bus_address = 64'h0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("tx_stall_valid", {63'b0, tx_valid}, 64'h1);
      chk("tx_stall_data", {56'b0, tx_data}, 64'h55);
    end
    tx_ready = 1'b1; cycle(); tx_ready = 1'b0;
    chk("tx_popped", {63'b0, tx_valid}, 64'h0);

    // Reset mid-transfer with a read and ack in the reset cycle
    push_key(8'h01); push_key(8'h02);
    bus_write_enable = 1'b1; bus_address = ART_BASE; bus_write_data = 64'h77;
    cycle();
    bus_write_enable = 1'b0;
    reset = 1'b1; interrupt_ack = 1'b1; bus_read_enable = 1'b1; bus_address = KEY_BASE;
    cycle();
    idle_inputs();
    chk("midrst_rd", bus_read_data, 64'h0);
    chk("midrst_txv", {63'b0, tx_valid}, 64'h0);
    chk("midrst_irq", {60'b0, interrupt_vector}, 64'h0);
    read_at(STAT_ADDR);
    chk("midrst_status", bus_read_data, 64'h0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int sel;
      reset     = ($urandom_range(0, 299) == 0);
      key_valid = ($urandom_range(0, 1) == 1);
      key_data  = 8'($urandom);
      tx_ready  = ($urandom_range(0, 2) == 0);
      bus_read_enable = ($urandom_range(0, 9) < 3);
      bus_write_enable = ($urandom_range(0, 9) < 4);
      bus_write_data = {$urandom, $urandom};
      sel = $urandom_range(0, 4);
      case (sel)
        0, 1:    bus_address = KEY_BASE;
        2:       bus_address = STAT_ADDR;
        3:       bus_address = ART_BASE;
        default: bus_address = {32'h0, $urandom};
      endcase
      if (bus_write_enable && $urandom_range(0, 1) == 1) bus_address = ART_BASE;
      cycle();
    end
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
